// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM state encoding,
// register-address type, counter width and the load-use hazard helper.
// No ports (package). Optional feature macro used elsewhere: PIPE_PERF_EN.
package pipeline_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int PERF_W = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  // A load in EX whose destination feeds the instruction in ID. Register x0
  // is hard-wired to zero, so a "load" to x0 never creates a dependency.
  function automatic logic load_use(
    input logic      ex_valid,
    input logic      ex_mem_read,
    input reg_addr_t ex_rd,
    input reg_addr_t id_rs1,
    input reg_addr_t id_rs2,
    input logic      id_uses_rs1,
    input logic      id_uses_rs2
  );
    logic hit1;
    logic hit2;
    hit1 = id_uses_rs1 && (id_rs1 == ex_rd);
    hit2 = id_uses_rs2 && (id_rs2 == ex_rd);
    return ex_valid && ex_mem_read && (ex_rd != '0) && (hit1 || hit2);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/stall controller.
// master = pipeline (drives hazard info, receives controls);
// slave  = controller (reads hazard info, drives pc/ifid/idex controls, mc_kill, busy).
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  // hazard information from the pipeline
  reg_addr_t ifid_rs1_addr;
  reg_addr_t ifid_rs2_addr;
  logic      ifid_uses_rs1;
  logic      ifid_uses_rs2;
  logic      idex_valid;
  logic      idex_mem_read;
  reg_addr_t idex_rd_addr;
  logic      ex_redirect;
  logic      mc_start;
  logic      mc_done;

  // controls back to the pipeline
  logic pc_stall;
  logic ifid_stall;
  logic ifid_flush;
  logic idex_stall;
  logic idex_flush;
  logic mc_kill;
  logic busy;

  modport master (
    output ifid_rs1_addr, ifid_rs2_addr, ifid_uses_rs1, ifid_uses_rs2,
           idex_valid, idex_mem_read, idex_rd_addr, ex_redirect, mc_start, mc_done,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, mc_kill, busy
  );

  modport slave (
    input  ifid_rs1_addr, ifid_rs2_addr, ifid_uses_rs1, ifid_uses_rs2,
           idex_valid, idex_mem_read, idex_rd_addr, ex_redirect, mc_start, mc_done,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, mc_kill, busy
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous preload; holds at all-ones.
// Ports: clk, reset_n (async, active-low), inc, load/load_val, count.
// Latency: count reflects inc/load one clock after the qualifying cycle.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: redirect flush, multi-cycle (mul/div) wait, load-use bubble.
// Ports: clk, reset_n (async, active-low), pif (pipeline_ctrl_if.slave); with
// PIPE_PERF_EN defined also perf_stall_cycles / perf_flush_count (saturating).
// Controls are combinational from state + inputs; busy is the registered FSM state.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  pipeline_ctrl_if.slave      pif
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0]   perf_stall_cycles,
  output logic [PERF_W-1:0]   perf_flush_count
`endif
);

  state_t state;
  state_t state_nxt;
  logic   lu;

  logic pc_stall_c;
  logic ifid_stall_c;
  logic ifid_flush_c;
  logic idex_stall_c;
  logic idex_flush_c;
  logic mc_kill_c;

  assign lu = load_use(pif.idex_valid, pif.idex_mem_read, pif.idex_rd_addr,
                       pif.ifid_rs1_addr, pif.ifid_rs2_addr,
                       pif.ifid_uses_rs1, pif.ifid_uses_rs2);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: a redirect always wins and drops any pending multi-cycle op
  always_comb begin
    state_nxt = state;
    if (pif.ex_redirect) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (pif.mc_start && !pif.mc_done) state_nxt = MC_WAIT;
        MC_WAIT: if (pif.mc_done) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // outputs, in priority order: redirect > multi-cycle wait > load-use
  always_comb begin
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    idex_stall_c = 1'b0;
    idex_flush_c = 1'b0;
    mc_kill_c    = 1'b0;
    if (pif.ex_redirect) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      // the multi-cycle unit is either mid-op or being started by the wrong-path instr
      mc_kill_c    = (state == MC_WAIT) || pif.mc_start;
    end else if ((state == MC_WAIT) || pif.mc_start) begin
      // a start that completes in the same cycle needs no freeze; lu is
      // deliberately not looked at here so it is only re-evaluated back in RUN
      pc_stall_c   = !pif.mc_done;
      ifid_stall_c = !pif.mc_done;
      idex_stall_c = !pif.mc_done;
    end else if (lu) begin
      // hold IF/ID and insert a bubble into EX
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_flush_c = 1'b1;
    end
  end

  // reset is asynchronous; gating keeps the controls quiet while it is held
  // regardless of what the pipeline presents
  assign pif.pc_stall   = reset_n & pc_stall_c;
  assign pif.ifid_stall = reset_n & ifid_stall_c;
  assign pif.ifid_flush = reset_n & ifid_flush_c;
  assign pif.idex_stall = reset_n & idex_stall_c;
  assign pif.idex_flush = reset_n & idex_flush_c;
  assign pif.mc_kill    = reset_n & mc_kill_c;
  assign pif.busy       = (state == MC_WAIT);

`ifdef PIPE_PERF_EN
  sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (pif.pc_stall),
    .load     (1'b0),
    .load_val ({PERF_W{1'b0}}),
    .count    (perf_stall_cycles)
  );

  sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (pif.idex_flush),
    .load     (1'b0),
    .load_val ({PERF_W{1'b0}}),
    .count    (perf_flush_count)
  );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios followed by
// randomized traffic, checked against a rule-level reference model.
// PIPE_PERF_EN builds also check the performance counters and counter saturation.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipeline_ctrl_if pif();

`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  pipeline_ctrl u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pif     (pif.slave)
`ifdef PIPE_PERF_EN
    ,
    .perf_stall_cycles (perf_stall),
    .perf_flush_count  (perf_flush)
`endif
  );

  int tests = 0;
  int fails = 0;

  // reference model state: is a multi-cycle op outstanding, and event counts
  bit      m_wait = 1'b0;
  longint  m_stall_cnt = 0;
  longint  m_flush_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // controls packed as {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, mc_kill, busy}
  function automatic logic [6:0] observed();
    return {pif.pc_stall, pif.ifid_stall, pif.ifid_flush, pif.idex_stall,
            pif.idex_flush, pif.mc_kill, pif.busy};
  endfunction

  function automatic bit model_lu();
    bit dep1, dep2;
    dep1 = pif.ifid_uses_rs1 && (pif.ifid_rs1_addr == pif.idex_rd_addr);
    dep2 = pif.ifid_uses_rs2 && (pif.ifid_rs2_addr == pif.idex_rd_addr);
    return pif.idex_valid && pif.idex_mem_read && (pif.idex_rd_addr != 0) && (dep1 || dep2);
  endfunction

  function automatic logic [6:0] expected();
    bit freeze;
    if (!reset_n) return 7'b0;
    if (pif.ex_redirect)
      return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, (m_wait || pif.mc_start), m_wait};
    if (m_wait || pif.mc_start) begin
      freeze = !pif.mc_done;
      return {freeze, freeze, 1'b0, freeze, 1'b0, 1'b0, m_wait};
    end
    if (model_lu()) return 7'b1100100;
    return 7'b0;
  endfunction

  function automatic bit next_wait();
    if (!reset_n || pif.ex_redirect) return 1'b0;
    if (m_wait) return !pif.mc_done;
    return pif.mc_start && !pif.mc_done;
  endfunction

  task automatic drive(input int rs1, input int rs2, input bit u1, input bit u2,
                       input bit v, input bit mr, input int rd,
                       input bit redir, input bit ms, input bit md);
    pif.ifid_rs1_addr = 5'(rs1);
    pif.ifid_rs2_addr = 5'(rs2);
    pif.ifid_uses_rs1 = u1;
    pif.ifid_uses_rs2 = u2;
    pif.idex_valid    = v;
    pif.idex_mem_read = mr;
    pif.idex_rd_addr  = 5'(rd);
    pif.ex_redirect   = redir;
    pif.mc_start      = ms;
    pif.mc_done       = md;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // one clock: check at negedge, advance the model at posedge, return just after it
  task automatic cycle(input string tag, input bit use_want, input logic [6:0] want);
    logic [6:0] exp;
    bit nw;
    @(negedge clk);
    exp = expected();
    check(tag, 32'(observed()), 32'(use_want ? want : exp));
`ifdef PIPE_PERF_EN
    if (!reset_n) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end
    check({tag, "_pstall"}, perf_stall, 32'(m_stall_cnt));
    check({tag, "_pflush"}, perf_flush, 32'(m_flush_cnt));
`endif
    nw = next_wait();
    @(posedge clk);
    m_wait = nw;
    if (reset_n) begin
      if (exp[6] && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (exp[2] && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
    end
    #1;
  endtask

`ifdef PIPE_PERF_EN
  logic        sc_inc, sc_load;
  logic [31:0] sc_load_val, sc_count;
  sat_counter #(.WIDTH(32)) u_sat (
    .clk(clk), .reset_n(reset_n), .inc(sc_inc), .load(sc_load),
    .load_val(sc_load_val), .count(sc_count)
  );
  initial begin
    sc_inc = 1'b0;
    sc_load = 1'b0;
    sc_load_val = 32'h0;
  end
`endif

  initial begin
    reset_n = 1'b0;
    // reset held with every event input active: controls must stay low
    drive(5, 5, 1, 1, 1, 1, 5, 1, 1, 0);
    #1;
    cycle("reset_busy_in", 1, 7'b0);
    idle();
    cycle("reset_idle", 1, 7'b0);
    reset_n = 1'b1;

    // load-use on rs2, then the load leaves EX
    drive(0, 5, 0, 1, 1, 1, 5, 0, 0, 0);
    cycle("lu_hit", 1, 7'b1100100);
    drive(0, 5, 0, 1, 1, 0, 5, 0, 0, 0);
    cycle("lu_clear", 1, 7'b0);

    // load to x0 never stalls
    drive(0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    cycle("x0_load", 1, 7'b0);

    // divide: start, three wait cycles, done in the fourth
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("mc_start", 1, 7'b1101000);
    idle();
    for (int i = 0; i < 3; i++) cycle("mc_wait", 1, 7'b1101001);
    pif.mc_done = 1'b1;
    cycle("mc_done", 1, 7'b0000001);
    idle();
    cycle("mc_after", 1, 7'b0);

    // redirect beats a simultaneous load-use
    drive(3, 0, 1, 0, 1, 1, 3, 1, 0, 0);
    cycle("redir_lu", 1, 7'b0010100);

    // start and done together in RUN: no freeze, no wait state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle("mc_same", 1, 7'b0);
    // stray done is ignored and load-use still applies
    drive(2, 0, 1, 0, 1, 1, 2, 0, 0, 1);
    cycle("done_stray", 1, 7'b1100100);

    // load-use ignored during a wait, re-evaluated after return to RUN
    drive(2, 0, 1, 0, 1, 1, 2, 0, 1, 0);
    cycle("lu_mstart", 1, 7'b1101000);
    pif.mc_start = 1'b0;
    cycle("lu_in_wait", 1, 7'b1101001);
    pif.mc_done = 1'b1;
    cycle("lu_done", 1, 7'b0000001);
    pif.mc_done = 1'b0;
    cycle("lu_back", 1, 7'b1100100);

    // redirect while waiting kills the op
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("k_start", 1, 7'b1101000);
    idle();
    cycle("k_wait", 1, 7'b1101001);
    pif.ex_redirect = 1'b1;
    cycle("k_redir", 1, 7'b0010111);
    idle();
    cycle("k_after", 1, 7'b0);

    // redirect kills an op being started in RUN
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle("k_start_redir", 1, 7'b0010110);
    idle();

    // reset pulse during a wait aborts it silently
    pif.mc_start = 1'b1;
    cycle("r_start", 1, 7'b1101000);
    idle();
    cycle("r_wait", 1, 7'b1101001);
    reset_n = 1'b0;
    pif.ex_redirect = 1'b1;
    cycle("r_reset", 1, 7'b0);
    reset_n = 1'b1;
    idle();
    cycle("r_release", 1, 7'b0);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 3) == 0));
      reset_n = ($urandom_range(0, 199) != 0);
      cycle("rand", 0, 7'b0);
    end
    reset_n = 1'b1;
    idle();
    cycle("rand_end", 0, 7'b0);

`ifdef PIPE_PERF_EN
    // counter saturation from a preloaded value
    sc_load = 1'b1;
    sc_load_val = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    sc_load = 1'b0;
    sc_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    sc_inc = 1'b0;
    check("sat_count", sc_count, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
